keypad_attempt_unit: RTL and testbench

- Control/compare slice of the keypad lock datapath.
- Routes the encoder's key-valid strobe to either the setpoint (SP) or user-input (UI) digit-shift chain.
- Compares the two 32-bit, 8-digit BCD codes for equality.
- Counts entry attempts in BCD and flags when the attempt limit is reached.
- Sits between the input encoder / shift-register arrays and the output (unlock/alarm) circuit.

---
 rtl/keypad_pkg.sv | 12 +
 rtl/bcd_attempt_counter.sv | 45 ++++
 rtl/keypad_attempt_unit.sv | 51 +++++
 tb/tb_keypad_attempt_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad lock datapath slice.
package keypad_pkg;

   localparam int CODE_W      = 32;
   localparam int BCD_DIGIT_W = 4;

   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

   localparam int ROUTE_UI = 0;
   localparam int ROUTE_SP = 1;

endpackage

// File: rtl/bcd_attempt_counter.sv
// Single-digit BCD attempt counter with clear priority and limit flag.
// Build option ATTEMPT_SATURATE_EN: hold at 9 instead of wrapping to 0.
module bcd_attempt_counter
   import keypad_pkg::*;
#(
   parameter int MAX_ATTEMPTS = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   inc,
   output logic [BCD_DIGIT_W-1:0] count,
   output logic                   limit
);

   logic [BCD_DIGIT_W-1:0] count_inc;

   // Increment value: 9 wraps (or holds), out-of-range codes recover to 0.
   always_comb begin
      count_inc = count + 4'd1;
      if (count > BCD_MAX) begin
         count_inc = '0;
      end else if (count == BCD_MAX) begin
`ifdef ATTEMPT_SATURATE_EN
         count_inc = BCD_MAX;
`else
         count_inc = '0;
`endif
      end
   end

   // Count register: reset beats clear, clear beats increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count_inc;
      end
   end

   assign limit = (count >= BCD_DIGIT_W'(MAX_ATTEMPTS));

endmodule

// File: rtl/keypad_attempt_unit.sv
// Keypad lock control/compare slice: key strobe demux, registered code
// equality, BCD attempt counter with limit flag.
// Build option ATTEMPT_SATURATE_EN: attempt counter saturates at 9.
module keypad_attempt_unit
   import keypad_pkg::*;
#(
   parameter int CODE_W       = keypad_pkg::CODE_W,
   parameter int MAX_ATTEMPTS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic              sel,
   input  logic [CODE_W-1:0] code_ui,
   input  logic [CODE_W-1:0] code_sp,
   input  logic              attempt_done,
   input  logic              clr_attempts,
   output logic [1:0]        route,
   output logic              match,
   output logic [3:0]        attempt_count,
   output logic              attempt_limit
);

   // Strobe demux: unselected leg is always a hard 0.
   always_comb begin
      route           = 2'b00;
      route[ROUTE_UI] = key_valid & sel;
      route[ROUTE_SP] = key_valid & ~sel;
   end

   // Full-width equality, registered; no BCD digit validation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         match <= 1'b0;
      end else begin
         match <= (code_ui == code_sp);
      end
   end

   bcd_attempt_counter #(
      .MAX_ATTEMPTS (MAX_ATTEMPTS)
   ) u_attempt_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_attempts),
      .inc   (attempt_done),
      .count (attempt_count),
      .limit (attempt_limit)
   );

endmodule

// File: tb/tb_keypad_attempt_unit.sv
// Directed bench for keypad_attempt_unit with hand-computed expectations.
module tb_keypad_attempt_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic        sel;
   logic [31:0] code_ui;
   logic [31:0] code_sp;
   logic        attempt_done;
   logic        clr_attempts;
   logic [1:0]  route;
   logic        match;
   logic [3:0]  attempt_count;
   logic        attempt_limit;

   int checks = 0;
   int errors = 0;

   keypad_attempt_unit #(
      .CODE_W       (32),
      .MAX_ATTEMPTS (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_valid     (key_valid),
      .sel           (sel),
      .code_ui       (code_ui),
      .code_sp       (code_sp),
      .attempt_done  (attempt_done),
      .clr_attempts  (clr_attempts),
      .route         (route),
      .match         (match),
      .attempt_count (attempt_count),
      .attempt_limit (attempt_limit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_done();
      attempt_done = 1'b1;
      tick();
      attempt_done = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      key_valid    = 1'b0;
      sel          = 1'b0;
      code_ui      = 32'h1234_5678;
      code_sp      = 32'h1234_5678;
      attempt_done = 1'b1;
      clr_attempts = 1'b0;

      // reset held two edges with pending attempt pulses and equal codes
      #2;
      tick();
      tick();
      check("rst_count", 32'(attempt_count), 32'h0);
      check("rst_match", 32'(match), 32'h0);
      check("rst_limit", 32'(attempt_limit), 32'h0);

      rst_n        = 1'b1;
      attempt_done = 1'b0;

      // demux
      sel = 1'b1; key_valid = 1'b1; #1;
      check("route_ui", 32'(route), 32'h1);
      sel = 1'b0; #1;
      check("route_sp", 32'(route), 32'h2);
      key_valid = 1'b0; #1;
      check("route_idle_sp", 32'(route), 32'h0);
      sel = 1'b1; #1;
      check("route_idle_ui", 32'(route), 32'h0);

      // comparator
      code_ui = 32'h2193_5488;
      code_sp = 32'h2193_5488;
      tick();
      check("match_eq", 32'(match), 32'h1);
      code_sp = 32'h2193_5487; #1;
      check("match_latency", 32'(match), 32'h1);
      tick();
      check("match_ne", 32'(match), 32'h0);
      code_ui = 32'h0; code_sp = 32'h0;
      tick();
      check("match_zero", 32'(match), 32'h1);
      code_ui = 32'h8000_0000;
      tick();
      check("match_msb", 32'(match), 32'h0);

      // attempts 1..5, limit at 5
      for (int i = 1; i <= 5; i++) begin
         pulse_done();
         check($sformatf("count_%0d", i), 32'(attempt_count), 32'(i));
         check($sformatf("limit_%0d", i), 32'(attempt_limit), (i >= 5) ? 32'h1 : 32'h0);
      end

      // 6..9 then the tenth pulse
      for (int i = 6; i <= 9; i++) begin
         pulse_done();
         check($sformatf("count_%0d", i), 32'(attempt_count), 32'(i));
      end
      pulse_done();
`ifdef ATTEMPT_SATURATE_EN
      check("count_sat", 32'(attempt_count), 32'h9);
      check("limit_sat", 32'(attempt_limit), 32'h1);
      pulse_done();
      check("count_sat2", 32'(attempt_count), 32'h9);
`else
      check("count_wrap", 32'(attempt_count), 32'h0);
      check("limit_wrap", 32'(attempt_limit), 32'h0);
`endif

      // clear, then attempt_done held three cycles counts three
      clr_attempts = 1'b1;
      tick();
      clr_attempts = 1'b0;
      check("count_clr", 32'(attempt_count), 32'h0);
      attempt_done = 1'b1;
      tick(); tick(); tick();
      attempt_done = 1'b0;
      check("count_held", 32'(attempt_count), 32'h3);

      // to 7, then simultaneous clear and attempt
      for (int i = 0; i < 4; i++) pulse_done();
      check("count_7", 32'(attempt_count), 32'h7);
      check("limit_7", 32'(attempt_limit), 32'h1);
      clr_attempts = 1'b1;
      attempt_done = 1'b1;
      tick();
      clr_attempts = 1'b0;
      attempt_done = 1'b0;
      check("count_prio", 32'(attempt_count), 32'h0);
      check("limit_prio", 32'(attempt_limit), 32'h0);

      // reset mid-operation drops pending pulse
      pulse_done();
      pulse_done();
      code_ui = 32'h5; code_sp = 32'h5;
      tick();
      check("match_pre_rst", 32'(match), 32'h1);
      rst_n        = 1'b0;
      attempt_done = 1'b1;
      tick();
      rst_n        = 1'b1;
      attempt_done = 1'b0;
      check("midrst_count", 32'(attempt_count), 32'h0);
      check("midrst_match", 32'(match), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
